// File: rtl/contador_regressivo_if.sv
// Control/status bundle for the countdown timer: request strobes in, count and flags out.
interface contador_regressivo_if #(
    parameter int LARGURA = 3
);
    logic               start;
    logic               cancel;
    logic               tick;
    logic [LARGURA-1:0] s;
    logic               busy;
    logic               fim;
    logic               alarme;

    modport master (
        output start, cancel, tick,
        input  s, busy, fim, alarme
    );

    modport slave (
        input  start, cancel, tick,
        output s, busy, fim, alarme
    );
endinterface

// File: rtl/contador_regressivo.sv
// Tick-driven countdown timer: load on start, count MODULO ticks, then latch an alarm
// until cancel acknowledges it. All outputs are registered.
module contador_regressivo #(
    parameter int MODULO  = 5,
    parameter int LARGURA = 3
) (
    input  logic                  clk,
    input  logic                  clear,
    contador_regressivo_if.slave  bus
);
    if (MODULO < 1 || (MODULO - 1) >= (1 << LARGURA)) begin : g_param_chk
        $error("contador_regressivo: MODULO-1 must fit in LARGURA bits");
    end

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        EXPIRADO = 2'd2
    } estado_t;

    localparam logic [LARGURA-1:0] CARGA = LARGURA'(MODULO - 1);

    estado_t            estado_q;
    logic [LARGURA-1:0] s_q;
    logic               busy_q;
    logic               fim_q;
    logic               alarme_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            estado_q <= OCIOSO;
            s_q      <= '0;
            busy_q   <= 1'b0;
            fim_q    <= 1'b0;
            alarme_q <= 1'b0;
        end else begin
            fim_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (start_req()) begin
                        estado_q <= CONTANDO;
                        s_q      <= CARGA;
                        busy_q   <= 1'b1;
                    end
                end
                CONTANDO: begin
                    // Priority: cancel, then restart, then tick.
                    if (bus.cancel) begin
                        estado_q <= OCIOSO;
                        s_q      <= '0;
                        busy_q   <= 1'b0;
                    end else if (bus.start) begin
                        s_q <= CARGA;
                    end else if (bus.tick) begin
                        if (s_q == '0) begin
                            estado_q <= EXPIRADO;
                            busy_q   <= 1'b0;
                            fim_q    <= 1'b1;
                            alarme_q <= 1'b1;
                        end else begin
                            s_q <= s_q - LARGURA'(1);
                        end
                    end
                end
                EXPIRADO: begin
                    if (bus.cancel) begin
                        estado_q <= OCIOSO;
                        alarme_q <= 1'b0;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                    s_q      <= '0;
                    busy_q   <= 1'b0;
                    alarme_q <= 1'b0;
                end
            endcase
        end
    end

    // A simultaneous cancel suppresses a start even from idle.
    function automatic logic start_req();
        return bus.start && !bus.cancel;
    endfunction

    assign bus.s      = s_q;
    assign bus.busy   = busy_q;
    assign bus.fim    = fim_q;
    assign bus.alarme = alarme_q;
endmodule

// File: doc/contador_regressivo.md
CONTADOR_REGRESSIVO -- requirements
Module: contador_regressivo

Interface
REQ-001 The block SHALL provide parameter MODULO, default 5, setting the countdown length in ticks.
REQ-002 The block SHALL provide parameter LARGURA, default 3, setting the count width; MODULO-1 SHALL fit in LARGURA bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 clear  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level-sampled request to load and begin the countdown.
REQ-006 cancel  input  1  level-sampled abort of the countdown, or acknowledgement of an alarm.
REQ-007 tick  input  1  single-cycle enable strobe; each high cycle is one countdown step.
REQ-008 s  output  LARGURA  current count value.
REQ-009 busy  output  1  high while the countdown is running.
REQ-010 fim  output  1  one-cycle pulse when the countdown expires.
REQ-011 alarme  output  1  level output, held high after expiry until acknowledged.

Function
REQ-012 The FSM SHALL have exactly three states: OCIOSO, CONTANDO and EXPIRADO.
REQ-013 OCIOSO outputs SHALL be s=0, busy=0 and alarme=0.
REQ-014 In OCIOSO, start=1 SHALL load s=MODULO-1 (4 by default) and enter CONTANDO at the same edge.
REQ-015 In OCIOSO, tick SHALL be ignored.
REQ-016 In CONTANDO, busy SHALL be 1.
REQ-017 In CONTANDO, tick=1 with s>0 SHALL decrement s by 1.
REQ-018 In CONTANDO, tick=1 with s=0 SHALL enter EXPIRADO and assert fim for exactly the following cycle.
REQ-019 s SHALL never wrap below 0.
REQ-020 From start, exactly MODULO tick strobes SHALL elapse before expiry.
REQ-021 In CONTANDO, tick=0 SHALL hold s.
REQ-022 In CONTANDO, start=1 without cancel SHALL reload s=MODULO-1 and remain in CONTANDO; this restart takes priority over a simultaneous tick.
REQ-023 In CONTANDO, cancel=1 SHALL return to OCIOSO with s=0 at the next edge.
REQ-024 cancel SHALL take priority over start and over tick in the same cycle.
REQ-025 In EXPIRADO, outputs SHALL be alarme=1, busy=0 and s=0.
REQ-026 In EXPIRADO, tick and start SHALL be ignored.
REQ-027 In EXPIRADO, cancel=1 SHALL return to OCIOSO and clear alarme at the next edge.
REQ-028 fim SHALL be high only in the first cycle of EXPIRADO and never otherwise.
REQ-029 All outputs SHALL be registered; no output SHALL depend combinationally on any input.
REQ-030 Each of s, busy, fim and alarme SHALL change only at a rising edge of clk.

Reset
REQ-031 clear=1 at a rising edge SHALL force OCIOSO with s=0, busy=0, fim=0 and alarme=0, regardless of all other inputs.
REQ-032 clear SHALL override any in-flight countdown or pending alarm.
REQ-033 The first edge with clear=0 SHALL behave as OCIOSO, so start in that cycle SHALL be honoured.
REQ-034 Reset SHALL have no asynchronous path.

Verification
REQ-035 Nominal countdown: clear pulse, start for 1 cycle, then 5 isolated ticks -> s goes 4,3,2,1,0; fim is high 1 cycle after the 5th tick; alarme=1 thereafter; busy falls in the same cycle.
REQ-036 Cancel mid-count: start, 2 ticks (s=2), cancel=1 -> next cycle s=0, busy=0; later ticks leave s=0 and alarme=0.
REQ-037 Restart and priority: at s=1, start=1 with tick=1 -> s=4; at s=3, start=1 with cancel=1 -> OCIOSO with s=0.
REQ-038 Alarm hold and acknowledge: after expiry, 10 ticks plus a start pulse -> alarme stays 1 and s=0; then cancel -> alarme=0; a new start then loads s=4.
REQ-039 Reset mid-operation: clear=1 at s=2, and separately in EXPIRADO -> all outputs 0 next cycle; start asserted in the first cycle after clear falls -> s=4.
REQ-040 Parameter sweep: MODULO=8 with LARGURA=3 -> exactly 8 ticks to fim; MODULO=1 -> s loads 0 and the first tick expires the countdown.
